// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger game blocks.
// Holds the FSM state encoding, the 16x16 field type and start/goal positions.
package frogger_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HIT  = 2'd1,
        WIN  = 2'd2,
        OVER = 2'd3
    } state_t;

    typedef logic [15:0][15:0] field_t;

    localparam logic [3:0] START_ROW  = 4'd0;
    localparam logic [3:0] START_COL  = 4'd7;
    localparam logic [3:0] GOAL_ROW   = 4'd15;
    localparam logic [1:0] LIVES_INIT = 2'd3;
    localparam logic [3:0] LEVEL_INIT = 4'b0001;
    localparam logic [3:0] LEVEL_MAX  = 4'b1000;

    // One-hot difficulty step that saturates at the hardest level.
    function automatic logic [3:0] next_level(input logic [3:0] lvl);
        logic [3:0] res;
        if (lvl == LEVEL_MAX) begin
            res = LEVEL_MAX;
        end else begin
            res = {lvl[2:0], 1'b0};
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronized, level-held button.
// On reset the previous-sample register loads the live value, so a held button never fires.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev_r;

    // Previous-sample register; reset and normal operation both load the live level.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= btn;
        end else begin
            prev_r <= btn;
        end
    end

    assign rise = btn & ~prev_r;

endmodule

// File: rtl/frog_ctrl.sv
// Frog controller: position, lives, level and game FSM (PLAY/HIT/WIN/OVER).
// The display field is decoded from the registered state and position.
module frog_ctrl
    import frogger_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  field_t     redArray,
    output field_t     greenArray,
    output logic       resetField,
    output logic [3:0] level,
    output logic [1:0] lives,
    output logic       gameOver
);

    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);

    state_t             state_r, state_s;
    logic [3:0]         row_r, row_s, col_r, col_s;
    logic [1:0]         lives_r, lives_s;
    logic [3:0]         level_r, level_s;
    logic [TIMER_W-1:0] timer_r, timer_s;
    logic               reset_field_r, reset_field_s;
    logic               game_over_r;
    logic               up_s, down_s, left_s, right_s;
    field_t             green_s;

    btn_edge u_edge_up    (.clk(clk), .reset(reset), .btn(btn_up),    .rise(up_s));
    btn_edge u_edge_down  (.clk(clk), .reset(reset), .btn(btn_down),  .rise(down_s));
    btn_edge u_edge_left  (.clk(clk), .reset(reset), .btn(btn_left),  .rise(left_s));
    btn_edge u_edge_right (.clk(clk), .reset(reset), .btn(btn_right), .rise(right_s));

    // Next-state, position, lives, level and timer decisions.
    always_comb begin
        state_s       = state_r;
        row_s         = row_r;
        col_s         = col_r;
        lives_s       = lives_r;
        level_s       = level_r;
        timer_s       = timer_r;
        reset_field_s = 1'b0;
        case (state_r)
            PLAY: begin
                if (pause) begin
                    state_s = PLAY;
                end else if (redArray[row_r][col_r]) begin
                    // Collision wins over any move; the last life goes straight to OVER.
                    if (lives_r == 2'd1) begin
                        state_s = OVER;
                        lives_s = 2'd0;
                    end else begin
                        state_s = HIT;
                        lives_s = lives_r - 2'd1;
                        timer_s = '0;
                    end
                end else if (row_r == GOAL_ROW) begin
                    state_s = WIN;
                end else if (!reset_field_r) begin
                    if (up_s) begin
                        if (row_r != 4'd15) row_s = row_r + 4'd1; else row_s = row_r;
                    end else if (down_s) begin
                        if (row_r != 4'd0) row_s = row_r - 4'd1; else row_s = row_r;
                    end else if (left_s) begin
                        if (col_r != 4'd15) col_s = col_r + 4'd1; else col_s = col_r;
                    end else if (right_s) begin
                        if (col_r != 4'd0) col_s = col_r - 4'd1; else col_s = col_r;
                    end else begin
                        state_s = PLAY;
                    end
                end else begin
                    state_s = PLAY;
                end
            end
            HIT: begin
                if (timer_r == HOLD_LAST) begin
                    state_s       = PLAY;
                    row_s         = START_ROW;
                    col_s         = START_COL;
                    timer_s       = '0;
                    reset_field_s = 1'b1;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            WIN: begin
                state_s       = PLAY;
                row_s         = START_ROW;
                col_s         = START_COL;
                level_s       = next_level(level_r);
                reset_field_s = 1'b1;
            end
            OVER: begin
                state_s = OVER;
            end
            default: begin
                state_s = PLAY;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= PLAY;
            row_r         <= START_ROW;
            col_r         <= START_COL;
            lives_r       <= LIVES_INIT;
            level_r       <= LEVEL_INIT;
            timer_r       <= '0;
            reset_field_r <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            row_r         <= row_s;
            col_r         <= col_s;
            lives_r       <= lives_s;
            level_r       <= level_s;
            timer_r       <= timer_s;
            reset_field_r <= reset_field_s;
            game_over_r   <= (state_s == OVER);
        end
    end

    // One-hot frog display, blanked once the game is over.
    always_comb begin
        green_s = '0;
        if (state_r != OVER) begin
            green_s[row_r][col_r] = 1'b1;
        end else begin
            green_s = '0;
        end
    end

    assign greenArray = green_s;
    assign resetField = reset_field_r;
    assign level      = level_r;
    assign lives      = lives_r;
    assign gameOver   = game_over_r;

endmodule
